// File: rtl/reset_logic.sv
// -----------------------------------------------------------------------------
// reset_logic
//
// Central reset conditioner for the core clock domain. Merges the external
// synchronous reset, a software reset request and an optional watchdog
// timeout into one registered, glitch-free active-high system reset. It also
// records the cause of the most recent reset event and counts reset events.
//
// Ports:
//   clk           in   rising-edge clock for all logic
//   reset_in      in   external reset, synchronous to clk, active-high
//   sw_reset_req  in   software reset request (pulse or level)
//   wdt_enable    in   watchdog enable
//   wdt_kick      in   clears the watchdog counter
//   reset_out     out  conditioned system reset, active-high, registered
//   reset_cause   out  cause of last event: 00 none, 01 ext, 10 sw, 11 wdt
//   reset_count   out  saturating count of reset events since power-up
// -----------------------------------------------------------------------------
module reset_logic #(
    parameter int STRETCH_CYCLES = 0,
    parameter int WDT_TIMEOUT    = 1024,
    parameter int WDT_WIDTH      = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 reset_in,
    input  logic                 sw_reset_req,
    input  logic                 wdt_enable,
    input  logic                 wdt_kick,
    output logic                 reset_out,
    output logic [1:0]           reset_cause,
    output logic [CNT_WIDTH-1:0] reset_count
);

    // Stretch counter needs to hold STRETCH_CYCLES; keep at least one bit so
    // the zero-stretch build still elaborates.
    localparam int SW = (STRETCH_CYCLES > 0) ? $clog2(STRETCH_CYCLES + 1) : 1;

    localparam logic [SW-1:0]        STRETCH_LD = SW'(STRETCH_CYCLES);
    localparam logic [WDT_WIDTH-1:0] WDT_LAST   = WDT_WIDTH'(WDT_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_WDT = 2'b11;

    // Power-up values: the system comes up in reset, nothing counted yet.
    logic                 r_reset_out = 1'b1;
    logic [SW-1:0]        r_stretch   = '0;
    logic [WDT_WIDTH-1:0] r_wdt_cnt   = '0;
    logic                 r_wdt_fire  = 1'b0;
    logic [1:0]           r_cause     = 2'b00;
    logic [CNT_WIDTH-1:0] r_count     = '0;

    logic w_src;
    logic w_event;
    logic w_wdt_hold;

    assign w_src      = reset_in | sw_reset_req | r_wdt_fire;
    // An event starts only when reset_out is about to rise from 0; sources
    // arriving during an existing reset or stretch window just extend it.
    assign w_event    = w_src & ~r_reset_out;
    // Kick has priority over counting; the watchdog also sleeps during reset.
    assign w_wdt_hold = ~wdt_enable | r_reset_out | wdt_kick;

    // Reset output with stretch; any new source reloads the stretch window.
    always_ff @(posedge clk) begin
        if (w_src) begin
            r_reset_out <= 1'b1;
            r_stretch   <= STRETCH_LD;
        end else if (r_stretch != '0) begin
            r_reset_out <= 1'b1;
            r_stretch   <= r_stretch - 1'b1;
        end else begin
            r_reset_out <= 1'b0;
        end
    end

    // Watchdog: the fire pulse is registered, so the reset it causes lands
    // one edge after the counter reaches its last value.
    always_ff @(posedge clk) begin
        if (w_wdt_hold) begin
            r_wdt_cnt  <= '0;
            r_wdt_fire <= 1'b0;
        end else if (r_wdt_cnt == WDT_LAST) begin
            r_wdt_cnt  <= '0;
            r_wdt_fire <= 1'b1;
        end else begin
            r_wdt_cnt  <= r_wdt_cnt + 1'b1;
            r_wdt_fire <= 1'b0;
        end
    end

    // Cause capture and event counting happen only at event start; the
    // external reset does not clear these debug registers.
    always_ff @(posedge clk) begin
        if (w_event) begin
            if (reset_in) begin
                r_cause <= CAUSE_EXT;
            end else if (sw_reset_req) begin
                r_cause <= CAUSE_SW;
            end else begin
                r_cause <= CAUSE_WDT;
            end
            if (r_count != CNT_MAX) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign reset_out   = r_reset_out;
    assign reset_cause = r_cause;
    assign reset_count = r_count;

endmodule

// File: tb/tb_reset_logic.sv
module tb_reset_logic;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: no stretch, watchdog timeout 8, 8-bit counter.
    logic       a_reset_in = 1'b0, a_sw = 1'b0, a_wen = 1'b0, a_kick = 1'b0;
    logic       a_reset_out;
    logic [1:0] a_cause;
    logic [7:0] a_count;

    // Instance B: stretch 3, watchdog timeout 8, 2-bit counter.
    logic       b_reset_in = 1'b0, b_sw = 1'b0, b_wen = 1'b0, b_kick = 1'b0;
    logic       b_reset_out;
    logic [1:0] b_cause;
    logic [1:0] b_count;

    reset_logic #(.STRETCH_CYCLES(0), .WDT_TIMEOUT(8), .WDT_WIDTH(16), .CNT_WIDTH(8)) u_a (
        .clk          (clk),
        .reset_in     (a_reset_in),
        .sw_reset_req (a_sw),
        .wdt_enable   (a_wen),
        .wdt_kick     (a_kick),
        .reset_out    (a_reset_out),
        .reset_cause  (a_cause),
        .reset_count  (a_count)
    );

    reset_logic #(.STRETCH_CYCLES(3), .WDT_TIMEOUT(8), .WDT_WIDTH(4), .CNT_WIDTH(2)) u_b (
        .clk          (clk),
        .reset_in     (b_reset_in),
        .sw_reset_req (b_sw),
        .wdt_enable   (b_wen),
        .wdt_kick     (b_kick),
        .reset_out    (b_reset_out),
        .reset_cause  (b_cause),
        .reset_count  (b_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Power-up state, before any edge.
        #1;
        chk("a_pwr_out",   8'(a_reset_out), 8'd1);
        chk("a_pwr_cause", 8'(a_cause),     8'd0);
        chk("a_pwr_count", a_count,         8'd0);
        chk("b_pwr_out",   8'(b_reset_out), 8'd1);

        // First edge with no sources: power-up reset released, not counted.
        tick();
        chk("a_release",   8'(a_reset_out), 8'd0);
        chk("a_rel_count", a_count,         8'd0);
        chk("b_release",   8'(b_reset_out), 8'd0);
        chk("b_rel_count", 8'(b_count),     8'd0);

        // External reset for one edge, then one edge low.
        a_reset_in = 1'b1;
        tick();
        chk("a_ext_out",   8'(a_reset_out), 8'd1);
        chk("a_ext_cause", 8'(a_cause),     8'd1);
        chk("a_ext_count", a_count,         8'd1);
        a_reset_in = 1'b0;
        tick();
        chk("a_ext_rel",   8'(a_reset_out), 8'd0);

        // Continuous external reset: held high, counted once.
        a_reset_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("a_cont_out", 8'(a_reset_out), 8'd1);
        end
        chk("a_cont_count", a_count, 8'd2);
        a_reset_in = 1'b0;
        tick();
        chk("a_cont_rel",   8'(a_reset_out), 8'd0);
        chk("a_cont_cnt2",  a_count,         8'd2);

        // Simultaneous external + software: one event, external wins.
        a_reset_in = 1'b1;
        a_sw       = 1'b1;
        tick();
        chk("a_sim_out",   8'(a_reset_out), 8'd1);
        chk("a_sim_cause", 8'(a_cause),     8'd1);
        chk("a_sim_count", a_count,         8'd3);
        a_reset_in = 1'b0;
        a_sw       = 1'b0;
        tick();
        chk("a_sim_rel",   8'(a_reset_out), 8'd0);
        chk("a_sim_cnt2",  a_count,         8'd3);

        // Software pulse without stretch.
        a_sw = 1'b1;
        tick();
        chk("a_sw_out",   8'(a_reset_out), 8'd1);
        chk("a_sw_cause", 8'(a_cause),     8'd2);
        chk("a_sw_count", a_count,         8'd4);
        a_sw = 1'b0;
        tick();
        chk("a_sw_rel",   8'(a_reset_out), 8'd0);

        // Watchdog, no kicks: reset rises on the 9th edge after enabling.
        a_wen = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("a_wdt_wait", 8'(a_reset_out), 8'd0);
        end
        tick();
        chk("a_wdt_out",   8'(a_reset_out), 8'd1);
        chk("a_wdt_cause", 8'(a_cause),     8'd3);
        chk("a_wdt_count", a_count,         8'd5);
        a_wen = 1'b0;
        tick();
        chk("a_wdt_rel",   8'(a_reset_out), 8'd0);
        chk("a_wdt_held",  8'(a_cause),     8'd3);

        // Watchdog kicked every 5 cycles: never fires.
        a_wen = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a_kick = ((i % 5) == 4);
            tick();
            chk("a_kick_out", 8'(a_reset_out), 8'd0);
        end
        a_kick = 1'b0;
        a_wen  = 1'b0;
        chk("a_kick_count", a_count, 8'd5);

        // B: one-cycle software pulse, stretched to exactly 4 high cycles.
        b_sw = 1'b1;
        tick();
        chk("b_sw_out",   8'(b_reset_out), 8'd1);
        chk("b_sw_cause", 8'(b_cause),     8'd2);
        chk("b_sw_count", 8'(b_count),     8'd1);
        b_sw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b_stretch", 8'(b_reset_out), 8'd1);
        end
        tick();
        chk("b_sw_rel", 8'(b_reset_out), 8'd0);

        // B: re-pulse on the 2nd high cycle reloads the stretch window.
        b_sw = 1'b1;
        tick();
        chk("b_rp_out1", 8'(b_reset_out), 8'd1);
        b_sw = 1'b0;
        tick();
        chk("b_rp_out2", 8'(b_reset_out), 8'd1);
        b_sw = 1'b1;
        tick();
        chk("b_rp_out3", 8'(b_reset_out), 8'd1);
        b_sw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b_rp_hold", 8'(b_reset_out), 8'd1);
        end
        tick();
        chk("b_rp_rel",   8'(b_reset_out), 8'd0);
        chk("b_rp_count", 8'(b_count),     8'd2);

        // B: three more software events, counter saturates at 3.
        for (int n = 0; n < 3; n++) begin
            b_sw = 1'b1;
            tick();
            chk("b_sat_out",   8'(b_reset_out), 8'd1);
            chk("b_sat_count", 8'(b_count),     8'd3);
            b_sw = 1'b0;
            for (int i = 0; i < 4; i++) tick();
            chk("b_sat_rel", 8'(b_reset_out), 8'd0);
        end

        // B: external reset with stretch, cause switches to external.
        b_reset_in = 1'b1;
        tick();
        chk("b_ext_out",   8'(b_reset_out), 8'd1);
        chk("b_ext_cause", 8'(b_cause),     8'd1);
        b_reset_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b_ext_hold", 8'(b_reset_out), 8'd1);
        end
        tick();
        chk("b_ext_rel",   8'(b_reset_out), 8'd0);
        chk("b_ext_count", 8'(b_count),     8'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
